// File: rtl/reservation_station.sv
// Single-entry Tomasulo reservation station: takes a task addressed to RS_TAG, snoops the CDB for
// missing operands, issues the task to its FU, and stays busy until its own result is broadcast.
module reservation_station #(
    parameter int                 TAG_W  = 3,
    parameter int                 XLEN   = 32,
    parameter logic [TAG_W-1:0]   RS_TAG = 3'd1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_disp_valid,
    input  logic [TAG_W-1:0] i_disp_rs,
    input  logic [6:0]       i_disp_op,
    input  logic [3:0]       i_disp_func,
    input  logic [XLEN-1:0]  i_disp_vj,
    input  logic [TAG_W-1:0] i_disp_qj,
    input  logic [XLEN-1:0]  i_disp_vk,
    input  logic [TAG_W-1:0] i_disp_qk,
    input  logic [XLEN-1:0]  i_disp_imm,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [XLEN-1:0]  i_cdb_data,
    input  logic             i_fu_ready,
    output logic             o_issue_valid,
    output logic [6:0]       o_issue_op,
    output logic [3:0]       o_issue_func,
    output logic [XLEN-1:0]  o_issue_a,
    output logic [XLEN-1:0]  o_issue_b,
    output logic [XLEN-1:0]  o_issue_imm,
    output logic [TAG_W-1:0] o_issue_tag,
    output logic             o_busy
);

    typedef enum logic [1:0] {IDLE, WAIT_OPS, READY, EXEC} state_t;

    state_t           r_state;
    logic [6:0]       r_op;
    logic [3:0]       r_func;
    logic [XLEN-1:0]  r_imm;
    logic [XLEN-1:0]  r_vj;
    logic [XLEN-1:0]  r_vk;
    logic [TAG_W-1:0] r_qj;
    logic [TAG_W-1:0] r_qk;

    logic w_accept;
    logic w_fwd_j;
    logic w_fwd_k;
    logic w_cap_j;
    logic w_cap_k;
    logic w_own_done;

    // Tag 0 means "value already valid", so a zero CDB tag can never resolve anything.
    assign w_accept   = i_disp_valid && (i_disp_rs == RS_TAG);
    assign w_fwd_j    = i_cdb_valid && (i_cdb_tag != '0) && (i_cdb_tag == i_disp_qj);
    assign w_fwd_k    = i_cdb_valid && (i_cdb_tag != '0) && (i_cdb_tag == i_disp_qk);
    assign w_cap_j    = i_cdb_valid && (r_qj != '0) && (i_cdb_tag == r_qj);
    assign w_cap_k    = i_cdb_valid && (r_qk != '0) && (i_cdb_tag == r_qk);
    assign w_own_done = i_cdb_valid && (i_cdb_tag == RS_TAG);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_func  <= '0;
            r_imm   <= '0;
            r_vj    <= '0;
            r_vk    <= '0;
            r_qj    <= '0;
            r_qk    <= '0;
        end else if (i_flush) begin
            r_state <= IDLE;
            r_qj    <= '0;
            r_qk    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= i_disp_op;
                        r_func  <= i_disp_func;
                        r_imm   <= i_disp_imm;
                        r_vj    <= w_fwd_j ? i_cdb_data : i_disp_vj;
                        r_vk    <= w_fwd_k ? i_cdb_data : i_disp_vk;
                        r_qj    <= w_fwd_j ? '0 : i_disp_qj;
                        r_qk    <= w_fwd_k ? '0 : i_disp_qk;
                        r_state <= ((w_fwd_j || i_disp_qj == '0) && (w_fwd_k || i_disp_qk == '0))
                                   ? READY : WAIT_OPS;
                    end
                end
                WAIT_OPS: begin
                    if (w_cap_j) begin
                        r_vj <= i_cdb_data;
                        r_qj <= '0;
                    end
                    if (w_cap_k) begin
                        r_vk <= i_cdb_data;
                        r_qk <= '0;
                    end
                    if ((r_qj == '0 || w_cap_j) && (r_qk == '0 || w_cap_k))
                        r_state <= READY;
                end
                READY: begin
                    if (i_fu_ready)
                        r_state <= EXEC;
                end
                EXEC: begin
                    // A same-cycle dispatch is dropped: the issue queue must observe BUSY low first.
                    if (w_own_done)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_issue_valid = (r_state == READY);
    assign o_busy        = (r_state != IDLE);
    assign o_issue_op    = r_op;
    assign o_issue_func  = r_func;
    assign o_issue_a     = r_vj;
    assign o_issue_b     = r_vk;
    assign o_issue_imm   = r_imm;
    assign o_issue_tag   = RS_TAG;

endmodule
